// File: rtl/hex_display_scheduler_if.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler_if
//   Bundles the value handshake and the display outputs of the
//   hex_display_scheduler.
//   master : value source. Drives in_valid, value_in and blank_lz. Observes
//            in_ready, seg_out, busy and done.
//   slave  : the scheduler itself.
//   Signals:
//     in_valid  value_in holds a word to display
//     in_ready  scheduler can accept a word this cycle
//     value_in  4*NUM_DIGITS-bit word, nibble k feeds digit k
//     blank_lz  leading-zero blanking request, sampled with the word
//     seg_out   7*NUM_DIGITS-bit active-low segments, digit k at [7k+6:7k]
//     busy      a scan or commit is in progress
//     done      one-cycle pulse when seg_out takes a new frame
// ---------------------------------------------------------------------------
interface hex_display_scheduler_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    blank_lz;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    busy;
    logic                    done;

    modport master (
        output in_valid, value_in, blank_lz,
        input  in_ready, seg_out, busy, done
    );

    modport slave (
        input  in_valid, value_in, blank_lz,
        output in_ready, seg_out, busy, done
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// hex_display_scheduler
//   Turns a word into active-low 7-segment patterns for NUM_DIGITS digits
//   using a single time-shared hex decoder. Digits are decoded from the most
//   significant nibble down into a shadow frame; once the last digit is
//   written the whole shadow frame is copied to seg_out in one edge, so the
//   display never shows a partly updated value.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset, blanks everything, returns to IDLE
//     clr    synchronous clear, aborts any scan and blanks everything
//     bus    slave side of hex_display_scheduler_if (handshake + outputs)
// ---------------------------------------------------------------------------
module hex_display_scheduler #(
    parameter int         NUM_DIGITS = 8,
    parameter int         UPDATE_DIV = 1,
    parameter logic [6:0] BLANK_SEG  = 7'h7F
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    hex_display_scheduler_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [7*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_SEG}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic                    lz_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DIV_W-1:0]        div_q;
    logic [7*NUM_DIGITS-1:0] shadow_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic                    done_q;

    logic                    ready;
    logic                    accept;
    logic                    digit_end;
    logic [3:0]              nibble;
    logic                    blank_now;

    // Shared hex -> 7-segment decoder, active-low, bit6=g .. bit0=a.
    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] seg;
        unique case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Ready is also held low while reset is asserted so nothing looks
    // acceptable to the source during reset.
    assign ready     = rst_n && (state_q == IDLE) && !clr;
    assign accept    = bus.in_valid && ready;
    assign digit_end = (state_q == SCAN) && (div_q == DIV_W'(UPDATE_DIV - 1));
    assign nibble    = value_q[4*idx_q +: 4];
    // Digit 0 is always shown so a zero value still reads "0".
    assign blank_now = lz_q && (nibble == 4'h0) && (idx_q != '0);

    assign bus.in_ready = ready;
    assign bus.seg_out  = seg_q;
    assign bus.busy     = (state_q == SCAN) || (state_q == COMMIT);
    assign bus.done     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (digit_end && (idx_q == '0)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    // The captured word only matters while a scan runs and is always loaded
    // on accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            value_q <= bus.value_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q     <= 1'b0;
            idx_q    <= IDX_W'(NUM_DIGITS - 1);
            div_q    <= '0;
            shadow_q <= ALL_BLANK;
            seg_q    <= ALL_BLANK;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr) begin
                shadow_q <= ALL_BLANK;
                seg_q    <= ALL_BLANK;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            lz_q  <= bus.blank_lz;
                            idx_q <= IDX_W'(NUM_DIGITS - 1);
                            div_q <= '0;
                        end
                    end
                    SCAN: begin
                        if (digit_end) begin
                            shadow_q[7*idx_q +: 7] <= blank_now ? BLANK_SEG : seg_decode(nibble);
                            if (nibble != 4'h0) begin
                                lz_q <= 1'b0;
                            end
                            // Index parks at 0 after the last digit; accept reloads it.
                            if (idx_q != '0) begin
                                idx_q <= idx_q - 1'b1;
                            end
                            div_q <= '0;
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                    COMMIT: begin
                        seg_q  <= shadow_q;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hex_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scheduler
//   Bench for hex_display_scheduler with two instances: UPDATE_DIV=1 (sel 0)
//   and UPDATE_DIV=4 (sel 1). Expected frames come from a digit-level model
//   built on a hex lookup table and the position of the most significant
//   nonzero nibble.
// ---------------------------------------------------------------------------
module tb_hex_display_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic clr1;
    logic clr4;
    int   total = 0;
    int   bad   = 0;

    localparam logic [55:0] BLANK = {8{7'h7F}};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [55:0] exp_frame [2];

    hex_display_scheduler_if #(.NUM_DIGITS(8)) bus1 ();
    hex_display_scheduler_if #(.NUM_DIGITS(8)) bus4 ();

    hex_display_scheduler #(.NUM_DIGITS(8), .UPDATE_DIV(1), .BLANK_SEG(7'h7F)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(bus1)
    );
    hex_display_scheduler #(.NUM_DIGITS(8), .UPDATE_DIV(4), .BLANK_SEG(7'h7F)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .bus(bus4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: digits above the most significant nonzero nibble are blank
    // when blanking is requested; digit 0 is never above it.
    function automatic logic [55:0] model(input logic [31:0] v, input bit blz);
        logic [55:0] f;
        logic [3:0]  nib;
        int          msd;
        msd = 0;
        for (int k = 0; k < 8; k++) begin
            if (((v >> (4*k)) & 32'hF) != 0) msd = k;
        end
        f = '0;
        for (int k = 0; k < 8; k++) begin
            nib = 4'((v >> (4*k)) & 32'hF);
            f[7*k +: 7] = (blz && k > msd) ? 7'h7F : SEG_TAB[nib];
        end
        return f;
    endfunction

    function automatic logic rd_ready(input bit s);
        return s ? bus4.in_ready : bus1.in_ready;
    endfunction
    function automatic logic rd_busy(input bit s);
        return s ? bus4.busy : bus1.busy;
    endfunction
    function automatic logic rd_done(input bit s);
        return s ? bus4.done : bus1.done;
    endfunction
    function automatic logic [55:0] rd_seg(input bit s);
        return s ? bus4.seg_out : bus1.seg_out;
    endfunction

    task automatic drive(input bit s, input logic vld, input logic [31:0] v, input logic blz);
        if (s) begin
            bus4.in_valid = vld; bus4.value_in = v; bus4.blank_lz = blz;
        end else begin
            bus1.in_valid = vld; bus1.value_in = v; bus1.blank_lz = blz;
        end
    endtask

    // Offer one word, then follow the scan to its commit. While scanning the
    // old frame must stay visible, ready must be low and busy high.
    task automatic run_frame(input bit s, input logic [31:0] v, input bit blz, input string tag);
        logic [55:0] want;
        int n, lat, glitches;
        want = model(v, blz);
        lat = s ? 33 : 9;
        glitches = 0;
        total++;
        if (rd_ready(s) !== 1'b1) begin
            bad++; $display("FAIL %s_ready_idle: got %b want 1", tag, rd_ready(s));
        end
        drive(s, 1'b1, v, blz);
        tick();
        drive(s, 1'b0, $urandom, ~blz);
        n = 0;
        while (rd_done(s) !== 1'b1 && n < 200) begin
            if (rd_ready(s) !== 1'b0 || rd_busy(s) !== 1'b1 || rd_seg(s) !== exp_frame[s]) glitches++;
            tick();
            n++;
        end
        total++;
        if (n != lat) begin
            bad++; $display("FAIL %s_latency: got %0d edges want %0d", tag, n, lat);
        end
        total++;
        if (glitches != 0) begin
            bad++; $display("FAIL %s_scan_cycles: got %0d bad cycles want 0", tag, glitches);
        end
        total++;
        if (rd_seg(s) !== want) begin
            bad++; $display("FAIL %s_frame: got %h want %h", tag, rd_seg(s), want);
        end
        exp_frame[s] = want;
        tick();
        total++;
        if (rd_done(s) !== 1'b0) begin
            bad++; $display("FAIL %s_done_pulse: got %b want 0", tag, rd_done(s));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr1 = 1'b0; clr4 = 1'b0;
        drive(0, 1'b1, 32'h1234_5678, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        tick(); tick();
        total++;
        if (bus1.seg_out !== BLANK) begin bad++; $display("FAIL reset_seg1: got %h want %h", bus1.seg_out, BLANK); end
        total++;
        if (bus4.seg_out !== BLANK) begin bad++; $display("FAIL reset_seg4: got %h want %h", bus4.seg_out, BLANK); end
        total++;
        if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus1.in_ready); end
        total++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            bad++; $display("FAIL reset_busy_done: got %b%b want 00", bus1.busy, bus1.done);
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus1.in_ready !== 1'b1 || bus4.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b%b want 11", bus1.in_ready, bus4.in_ready);
        end
        exp_frame[0] = BLANK;
        exp_frame[1] = BLANK;
    endtask

    task automatic test_deadbeef();
        run_frame(0, 32'hDEAD_BEEF, 1'b0, "deadbeef");
        total++;
        if (bus1.seg_out !== {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}) begin
            bad++; $display("FAIL deadbeef_const: got %h", bus1.seg_out);
        end
    endtask

    task automatic test_blanking();
        run_frame(0, 32'h0000_00A5, 1'b1, "lz_a5");
        total++;
        if (bus1.seg_out !== {{6{7'h7F}}, 7'h08, 7'h12}) begin
            bad++; $display("FAIL lz_a5_const: got %h", bus1.seg_out);
        end
        run_frame(0, 32'h0, 1'b1, "lz_zero");
        total++;
        if (bus1.seg_out !== {{7{7'h7F}}, 7'h40}) begin
            bad++; $display("FAIL lz_zero_const: got %h", bus1.seg_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va, vb;
        int n, glitches;
        va = $urandom; vb = $urandom;
        drive(0, 1'b1, va, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        tick(); tick(); tick();
        drive(0, 1'b1, vb, 1'b0);
        total++;
        if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_mid_ready: got %b want 0", bus1.in_ready); end
        n = 0; glitches = 0;
        while (bus1.done !== 1'b1 && n < 200) begin
            if (bus1.in_ready !== 1'b0 || bus1.seg_out !== exp_frame[0]) glitches++;
            tick();
            n++;
        end
        total++;
        if (glitches != 0) begin bad++; $display("FAIL b2b_hold_first: got %0d bad cycles want 0", glitches); end
        total++;
        if (bus1.seg_out !== model(va, 1'b0)) begin
            bad++; $display("FAIL b2b_first_frame: got %h want %h", bus1.seg_out, model(va, 1'b0));
        end
        exp_frame[0] = model(va, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        total++;
        if (bus1.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got busy %b want 1", bus1.busy); end
        n = 0; glitches = 0;
        while (bus1.done !== 1'b1 && n < 200) begin
            if (bus1.seg_out !== exp_frame[0]) glitches++;
            tick();
            n++;
        end
        total++;
        if (n != 9 || glitches != 0) begin
            bad++; $display("FAIL b2b_second_scan: got %0d edges %0d bad cycles want 9 and 0", n, glitches);
        end
        total++;
        if (bus1.seg_out !== model(vb, 1'b0)) begin
            bad++; $display("FAIL b2b_second_frame: got %h want %h", bus1.seg_out, model(vb, 1'b0));
        end
        exp_frame[0] = model(vb, 1'b0);
        tick();
    endtask

    task automatic test_clr();
        int pulses;
        drive(0, 1'b1, $urandom | 32'h1, 1'b0);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0);
        tick(); tick(); tick();
        clr1 = 1'b1;
        tick();
        total++;
        if (bus1.seg_out !== BLANK) begin bad++; $display("FAIL clr_seg: got %h want %h", bus1.seg_out, BLANK); end
        total++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            bad++; $display("FAIL clr_busy_done: got %b%b want 00", bus1.busy, bus1.done);
        end
        drive(0, 1'b1, 32'h5555_5555, 1'b0);
        total++;
        if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", bus1.in_ready); end
        tick();
        clr1 = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0);
        total++;
        if (bus1.busy !== 1'b0) begin bad++; $display("FAIL clr_no_accept: got busy %b want 0", bus1.busy); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus1.done === 1'b1 || bus1.seg_out !== BLANK) pulses++;
            tick();
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL clr_quiet: got %0d active cycles want 0", pulses); end
        exp_frame[0] = BLANK;
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 12; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            run_frame(0, v, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_div4();
        run_frame(1, 32'h1234_5678, 1'b0, "div4");
        total++;
        if (bus4.seg_out !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}) begin
            bad++; $display("FAIL div4_const: got %h", bus4.seg_out);
        end
        run_frame(1, $urandom >> 8, 1'b1, "div4_rand");
        drive(1, 1'b1, 32'h89AB_CDEF, 1'b0);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus4.seg_out !== BLANK || bus1.seg_out !== BLANK) begin
            bad++; $display("FAIL div4_rst_seg: got %h %h want %h", bus4.seg_out, bus1.seg_out, BLANK);
        end
        total++;
        if (bus4.busy !== 1'b0 || bus4.in_ready !== 1'b0) begin
            bad++; $display("FAIL div4_rst_ctrl: got busy %b ready %b want 0 0", bus4.busy, bus4.in_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL div4_rst_idle: got %b want 1", bus4.in_ready); end
        tick();
        total++;
        if (bus4.busy !== 1'b0 || bus4.seg_out !== BLANK) begin
            bad++; $display("FAIL div4_no_resume: got busy %b seg %h", bus4.busy, bus4.seg_out);
        end
        exp_frame[0] = BLANK;
        exp_frame[1] = BLANK;
        run_frame(1, 32'h0000_0F00, 1'b1, "div4_after_rst");
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_blanking();
        test_back_to_back();
        test_clr();
        test_random();
        test_div4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
